decode_stage: RTL and testbench
===============================

# decode_stage

Registered instruction-decode stage for the pipelined RV32I core. Sits between the IF/ID register and EX, and drives the EX stage with a registered control bundle. Decodes each instruction into the core's control-signal set with a valid/ready handshake on both sides. Adds a load-use interlock, a flush from EX, and illegal-instruction trapping with a stall counter. Optional RV32M decode is selected at compile time.

## Interface
- `CNT_W`, default 16: width of the saturating bubble/stall counter.
- `clk` input, 1 bit: clock; all state updates on the rising edge.
- `rst` input, 1 bit: synchronous, active-high reset.
- `if_valid` input, 1 bit: `if_instr`/`if_pc` hold a fetched instruction.
- `if_ready` output, 1 bit: the stage accepts the instruction this cycle.
- `if_instr` input, 32 bits: instruction word.
- `if_pc` input, 32 bits: instruction address.
- `flush` input, 1 bit: redirect from EX (taken branch/jump); kills the held and incoming instruction.
- `ex_ready` input, 1 bit: EX consumes the bundle this cycle.
- `ex_valid` output, 1 bit: bundle valid.
- `ex_pc`, `ex_instr` outputs, 32 bits each: registered copies.
- `ex_rd` output, 5 bits: destination register.
- `ex_regwrite`, `ex_memwrite`, `ex_alusrc`, `ex_is_load` outputs, 1 bit each: control signals.
- `ex_extop` output, 6 bits: one-hot immediate type, bits 5..0 = shamt, I, S, B, U, J.
- `ex_aluop` output, 5 bits: ALU operation.
- `ex_npcop` output, 3 bits: 000 PC+4, 001 branch, 010 jal, 100 jalr.
- `ex_dmtype` output, 3 bits: 000 word, 001 half, 010 half-unsigned, 011 byte, 100 byte-unsigned.
- `ex_wdsel` output, 2 bits: 00 ALU, 01 memory, 10 PC+4.
- `ex_illegal` output, 1 bit: the bundle is an undecodable instruction.
- `trapped` output, 1 bit: the stage is in TRAP.
- `stall_cnt` output, `CNT_W` bits: count of load-use bubbles inserted, saturating.

## Operation
- **Decode.** RV32I base: R-type, I-type ALU, loads, stores, branches, jal, jalr, lui, auipc. `use_rs1` covers R, I-ALU, load, store, branch and jalr; `use_rs2` covers R, store and branch.
- **ALUOp encoding.**
  - nop 0, lui 1, auipc 2, add 3, sub 4, bne 5, blt 6, bge 7, bltu 8, bgeu 9, slt 10, sltu 11, xor 12, or 13, and 14, sll 15, srl 16, sra 17.
  - beq uses sub (4).
  - Loads, stores and jalr use add (3).
  - Immediate forms use the same code as their register forms.
- **RegWrite/ALUSrc/WDSel/NPCOp/DMType** follow the standard RV32I mapping. jal also sets `ex_alusrc`.
- **Illegal instructions.** Any unrecognised opcode/funct3/funct7 combination produces `ex_illegal`=1 with every other control bit 0 and `ex_aluop`=0.
- **Load-use hazard.** `hazard` = `if_valid` & `ex_valid` & `ex_is_load` & (`ex_rd`≠0) & ((`use_rs1` & rs1==`ex_rd`) | (`use_rs2` & rs2==`ex_rd`)).
- **Handshake.**
  - `if_ready` = state==RUN & ~`flush` & ~`hazard` & (~`ex_valid` | `ex_ready`).
  - Accept = `if_valid` & `if_ready`; on accept the decoded bundle is registered with `ex_valid`=1.
  - If the register is free (~`ex_valid` | `ex_ready`) and there is no accept, `ex_valid`<=0. On a hazard this inserts exactly one bubble, after which the hazard clears.
  - If `ex_valid` & ~`ex_ready`, the bundle holds stable.
- **State machine** (RUN, TRAP):
  - RUN -> TRAP when an illegal instruction is accepted.
  - In TRAP, `if_ready`=0. The illegal bundle drains normally.
  - TRAP -> RUN only on `flush`.
- **Flush** has highest priority over everything: `ex_valid`<=0, state<=RUN, no accept that cycle.
- **stall_cnt** increments in a cycle when `hazard` & (~`ex_valid` | `ex_ready`) & ~`flush`. It saturates at all-ones.

## Timing
- Decode latency is 1 cycle: the instruction accepted at edge N is visible on `ex_*` after edge N.
- Throughput is 1 instruction/cycle without hazards.
- A load-use pair costs exactly 1 bubble cycle.
- Reset values: `ex_valid`=0, all `ex_*` control fields 0, `ex_pc`/`ex_instr`/`ex_rd`=0, `ex_illegal`=0, `trapped`=0, `stall_cnt`=0, state RUN. `if_ready` follows combinationally and is 0 while `rst`=1.
- Reset asserted mid-stream discards the held bundle.
- `flush` together with `hazard` or `ex_ready`=0: flush wins, and the counter does not increment.
- `ex_rd`=0 never causes an interlock.

## Configuration
- `DECODE_RV32M_EN` defined: opcode 0110011 with funct7=0000001 decodes to ALUOp mul 18, mulh 19, mulhsu 20, mulhu 21, div 22, divu 23, rem 24, remu 25, with RegWrite=1, WDSel=00, ALUSrc=0.
- Not defined: those encodings are illegal (`ex_illegal`=1, TRAP entered).

## Test plan
- Reset, then addi x1,x0,5 (0x00500093) with `ex_ready`=1 -> next cycle `ex_valid`=1, `ex_aluop`=3, `ex_alusrc`=1, `ex_extop`=010000, `ex_rd`=1.
- lw x2,0(x1), then add x3,x2,x2, streaming -> one cycle with `ex_valid`=0, `if_ready`=0 during the bubble, `stall_cnt`=1, then add issues with `ex_aluop`=3.
- `ex_ready`=0 for 3 cycles holding sub x5,x6,x7 -> `ex_*` stable with `ex_aluop`=4, `if_ready`=0; releases on the cycle `ex_ready`=1.
- Word 0xFFFFFFFF -> `ex_illegal`=1, `trapped`=1, `if_ready`=0 until `flush`; then `trapped`=0 and the next addi is accepted.
- mul x1,x2,x3 (0x023100B3) -> with `DECODE_RV32M_EN`: `ex_aluop`=18, no trap; without it: `ex_illegal`=1.
- `flush` asserted together with a valid hazard and `ex_valid`=1 -> next cycle `ex_valid`=0, `stall_cnt` unchanged.

Source files
------------

// File: rtl/decode_stage_if.sv
// decode_stage_if: IF-side and EX-side handshake/bundle signals of decode_stage.
// slave = the decode stage itself, master = the surrounding pipeline.
interface decode_stage_if #(
  parameter int CNT_W = 16
);
  logic             if_valid;
  logic             if_ready;
  logic [31:0]      if_instr;
  logic [31:0]      if_pc;
  logic             flush;
  logic             ex_ready;
  logic             ex_valid;
  logic [31:0]      ex_pc;
  logic [31:0]      ex_instr;
  logic [4:0]       ex_rd;
  logic             ex_regwrite;
  logic             ex_memwrite;
  logic             ex_alusrc;
  logic             ex_is_load;
  logic [5:0]       ex_extop;
  logic [4:0]       ex_aluop;
  logic [2:0]       ex_npcop;
  logic [2:0]       ex_dmtype;
  logic [1:0]       ex_wdsel;
  logic             ex_illegal;
  logic             trapped;
  logic [CNT_W-1:0] stall_cnt;

  modport slave (
    input  if_valid, if_instr, if_pc, flush, ex_ready,
    output if_ready, ex_valid, ex_pc, ex_instr, ex_rd, ex_regwrite, ex_memwrite,
           ex_alusrc, ex_is_load, ex_extop, ex_aluop, ex_npcop, ex_dmtype,
           ex_wdsel, ex_illegal, trapped, stall_cnt
  );

  modport master (
    output if_valid, if_instr, if_pc, flush, ex_ready,
    input  if_ready, ex_valid, ex_pc, ex_instr, ex_rd, ex_regwrite, ex_memwrite,
           ex_alusrc, ex_is_load, ex_extop, ex_aluop, ex_npcop, ex_dmtype,
           ex_wdsel, ex_illegal, trapped, stall_cnt
  );
endinterface

// File: rtl/decode_stage.sv
// decode_stage: registered RV32I decode, 1-cycle latency; bundle holds while ex_ready is low,
// if_ready drops on hold/load-use/trap/flush. Define DECODE_RV32M_EN to decode RV32M instead of trapping.
module decode_stage #(
  parameter int CNT_W = 16
) (
  input  logic          clk,
  input  logic          rst,
  decode_stage_if.slave bus
);

  typedef struct packed {
    logic [4:0] rd;
    logic       regwrite;
    logic       memwrite;
    logic       alusrc;
    logic       is_load;
    logic [5:0] extop;
    logic [4:0] aluop;
    logic [2:0] npcop;
    logic [2:0] dmtype;
    logic [1:0] wdsel;
    logic       illegal;
  } ctrl_t;

  typedef enum logic {RUN, TRAP} state_t;

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_IMM   = 7'b0010011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;

  localparam logic [5:0] EXT_SHAMT = 6'b100000;
  localparam logic [5:0] EXT_I     = 6'b010000;
  localparam logic [5:0] EXT_S     = 6'b001000;
  localparam logic [5:0] EXT_B     = 6'b000100;
  localparam logic [5:0] EXT_U     = 6'b000010;
  localparam logic [5:0] EXT_J     = 6'b000001;

  localparam logic [4:0] ALU_LUI = 5'd1,  ALU_AUIPC = 5'd2,  ALU_ADD = 5'd3,  ALU_SUB = 5'd4;
  localparam logic [4:0] ALU_BNE = 5'd5,  ALU_BLT = 5'd6,    ALU_BGE = 5'd7,  ALU_BLTU = 5'd8;
  localparam logic [4:0] ALU_BGEU = 5'd9, ALU_SLT = 5'd10,   ALU_SLTU = 5'd11, ALU_XOR = 5'd12;
  localparam logic [4:0] ALU_OR = 5'd13,  ALU_AND = 5'd14,   ALU_SLL = 5'd15, ALU_SRL = 5'd16;
  localparam logic [4:0] ALU_SRA = 5'd17;
`ifdef DECODE_RV32M_EN
  localparam logic [4:0] ALU_MUL = 5'd18;
`endif

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic [4:0] rs1, rs2;

  assign opcode = bus.if_instr[6:0];
  assign funct3 = bus.if_instr[14:12];
  assign funct7 = bus.if_instr[31:25];
  assign rs1    = bus.if_instr[19:15];
  assign rs2    = bus.if_instr[24:20];

  ctrl_t  dec;
  logic   use_rs1, use_rs2, legal;

  always_comb begin
    dec     = '0;
    use_rs1 = 1'b0;
    use_rs2 = 1'b0;
    legal   = 1'b1;
    case (opcode)
      OP_R: begin
        dec.regwrite = 1'b1;
        use_rs1      = 1'b1;
        use_rs2      = 1'b1;
        case ({funct7, funct3})
          {7'h00, 3'd0}: dec.aluop = ALU_ADD;
          {7'h20, 3'd0}: dec.aluop = ALU_SUB;
          {7'h00, 3'd1}: dec.aluop = ALU_SLL;
          {7'h00, 3'd2}: dec.aluop = ALU_SLT;
          {7'h00, 3'd3}: dec.aluop = ALU_SLTU;
          {7'h00, 3'd4}: dec.aluop = ALU_XOR;
          {7'h00, 3'd5}: dec.aluop = ALU_SRL;
          {7'h20, 3'd5}: dec.aluop = ALU_SRA;
          {7'h00, 3'd6}: dec.aluop = ALU_OR;
          {7'h00, 3'd7}: dec.aluop = ALU_AND;
          default:       legal     = 1'b0;
        endcase
`ifdef DECODE_RV32M_EN
        if (funct7 == 7'h01) begin
          dec.aluop = ALU_MUL + {2'b00, funct3};
          legal     = 1'b1;
        end
`endif
      end
      OP_IMM: begin
        dec.regwrite = 1'b1;
        dec.alusrc   = 1'b1;
        dec.extop    = EXT_I;
        use_rs1      = 1'b1;
        case (funct3)
          3'd0: dec.aluop = ALU_ADD;
          3'd2: dec.aluop = ALU_SLT;
          3'd3: dec.aluop = ALU_SLTU;
          3'd4: dec.aluop = ALU_XOR;
          3'd6: dec.aluop = ALU_OR;
          3'd7: dec.aluop = ALU_AND;
          3'd1: begin
            dec.extop = EXT_SHAMT;
            dec.aluop = ALU_SLL;
            legal     = (funct7 == 7'h00);
          end
          default: begin  // 3'd5: srli/srai share funct3, funct7 selects
            dec.extop = EXT_SHAMT;
            dec.aluop = (funct7 == 7'h20) ? ALU_SRA : ALU_SRL;
            legal     = (funct7 == 7'h00) || (funct7 == 7'h20);
          end
        endcase
      end
      OP_LOAD: begin
        dec.regwrite = 1'b1;
        dec.alusrc   = 1'b1;
        dec.is_load  = 1'b1;
        dec.extop    = EXT_I;
        dec.aluop    = ALU_ADD;
        dec.wdsel    = 2'b01;
        use_rs1      = 1'b1;
        case (funct3)
          3'd0:    dec.dmtype = 3'b011;
          3'd1:    dec.dmtype = 3'b001;
          3'd2:    dec.dmtype = 3'b000;
          3'd4:    dec.dmtype = 3'b100;
          3'd5:    dec.dmtype = 3'b010;
          default: legal      = 1'b0;
        endcase
      end
      OP_STORE: begin
        dec.memwrite = 1'b1;
        dec.alusrc   = 1'b1;
        dec.extop    = EXT_S;
        dec.aluop    = ALU_ADD;
        use_rs1      = 1'b1;
        use_rs2      = 1'b1;
        case (funct3)
          3'd0:    dec.dmtype = 3'b011;
          3'd1:    dec.dmtype = 3'b001;
          3'd2:    dec.dmtype = 3'b000;
          default: legal      = 1'b0;
        endcase
      end
      OP_BR: begin
        dec.extop = EXT_B;
        dec.npcop = 3'b001;
        use_rs1   = 1'b1;
        use_rs2   = 1'b1;
        case (funct3)
          3'd0:    dec.aluop = ALU_SUB;
          3'd1:    dec.aluop = ALU_BNE;
          3'd4:    dec.aluop = ALU_BLT;
          3'd5:    dec.aluop = ALU_BGE;
          3'd6:    dec.aluop = ALU_BLTU;
          3'd7:    dec.aluop = ALU_BGEU;
          default: legal     = 1'b0;
        endcase
      end
      OP_JAL: begin
        dec.regwrite = 1'b1;
        dec.alusrc   = 1'b1;
        dec.extop    = EXT_J;
        dec.npcop    = 3'b010;
        dec.wdsel    = 2'b10;
      end
      OP_JALR: begin
        dec.regwrite = 1'b1;
        dec.alusrc   = 1'b1;
        dec.extop    = EXT_I;
        dec.aluop    = ALU_ADD;
        dec.npcop    = 3'b100;
        dec.wdsel    = 2'b10;
        use_rs1      = 1'b1;
        legal        = (funct3 == 3'd0);
      end
      OP_LUI: begin
        dec.regwrite = 1'b1;
        dec.alusrc   = 1'b1;
        dec.extop    = EXT_U;
        dec.aluop    = ALU_LUI;
      end
      OP_AUIPC: begin
        dec.regwrite = 1'b1;
        dec.alusrc   = 1'b1;
        dec.extop    = EXT_U;
        dec.aluop    = ALU_AUIPC;
      end
      default: legal = 1'b0;
    endcase
    // rd is only meaningful for writers; stores/branches carry immediate bits there
    dec.rd = dec.regwrite ? bus.if_instr[11:7] : 5'd0;
    if (!legal) begin
      dec         = '0;
      dec.illegal = 1'b1;
      use_rs1     = 1'b0;
      use_rs2     = 1'b0;
    end
  end

  state_t           state_q, state_d;
  logic             ex_valid_q;
  ctrl_t            ex_ctrl_q;
  logic [31:0]      ex_pc_q, ex_instr_q;
  logic [CNT_W-1:0] cnt_q;
  logic             reg_free, hazard, if_ready_int, accept;

  assign reg_free = ~ex_valid_q | bus.ex_ready;
  assign hazard   = bus.if_valid & ex_valid_q & ex_ctrl_q.is_load & (ex_ctrl_q.rd != 5'd0) &
                    ((use_rs1 & (rs1 == ex_ctrl_q.rd)) | (use_rs2 & (rs2 == ex_ctrl_q.rd)));
  assign if_ready_int = ~rst & (state_q == RUN) & ~bus.flush & ~hazard & reg_free;
  assign accept       = bus.if_valid & if_ready_int;

  always_comb begin
    state_d = state_q;
    if (bus.flush) begin
      state_d = RUN;
    end else if ((state_q == RUN) && accept && dec.illegal) begin
      state_d = TRAP;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= RUN;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_valid_q <= 1'b0;
      ex_ctrl_q  <= '0;
      ex_pc_q    <= '0;
      ex_instr_q <= '0;
    end else if (bus.flush) begin
      ex_valid_q <= 1'b0;
    end else if (accept) begin
      ex_valid_q <= 1'b1;
      ex_ctrl_q  <= dec;
      ex_pc_q    <= bus.if_pc;
      ex_instr_q <= bus.if_instr;
    end else if (reg_free) begin
      ex_valid_q <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (hazard && reg_free && !bus.flush && !(&cnt_q)) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign bus.if_ready    = if_ready_int;
  assign bus.ex_valid    = ex_valid_q;
  assign bus.ex_pc       = ex_pc_q;
  assign bus.ex_instr    = ex_instr_q;
  assign bus.ex_rd       = ex_ctrl_q.rd;
  assign bus.ex_regwrite = ex_ctrl_q.regwrite;
  assign bus.ex_memwrite = ex_ctrl_q.memwrite;
  assign bus.ex_alusrc   = ex_ctrl_q.alusrc;
  assign bus.ex_is_load  = ex_ctrl_q.is_load;
  assign bus.ex_extop    = ex_ctrl_q.extop;
  assign bus.ex_aluop    = ex_ctrl_q.aluop;
  assign bus.ex_npcop    = ex_ctrl_q.npcop;
  assign bus.ex_dmtype   = ex_ctrl_q.dmtype;
  assign bus.ex_wdsel    = ex_ctrl_q.wdsel;
  assign bus.ex_illegal  = ex_ctrl_q.illegal;
  assign bus.trapped     = (state_q == TRAP);
  assign bus.stall_cnt   = cnt_q;

endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: directed test-plan sequences then random traffic, scoreboarded
// against a table-driven reference decoder and a transaction-level pipeline model.
module tb_decode_stage;
  localparam int CNT_W = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  decode_stage_if #(.CNT_W(CNT_W)) bus ();
  decode_stage #(.CNT_W(CNT_W)) dut (.clk(clk), .rst(rst), .bus(bus.slave));

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [4:0]  rd;
    logic        regwrite, memwrite, alusrc, is_load;
    logic [5:0]  extop;
    logic [4:0]  aluop;
    logic [2:0]  npcop, dmtype;
    logic [1:0]  wdsel;
    logic        illegal;
    logic        use1, use2;
  } exp_t;

  int   n_chk = 0;
  int   n_err = 0;
  exp_t exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference decoder: per-format lookup tables indexed by funct3, -1 = reserved.
  function automatic exp_t ref_decode(input logic [31:0] ins, input logic [31:0] pc);
    exp_t e;
    int   r_op[8];
    int   br_op[8];
    int   ld_dm[8];
    int   st_dm[8];
    int   f3;
    logic [6:0] f7;
    bit   ok;
    r_op  = '{3, 15, 10, 11, 12, 16, 13, 14};
    br_op = '{4, 5, -1, -1, 6, 7, 8, 9};
    ld_dm = '{3, 1, 0, -1, 4, 2, -1, -1};
    st_dm = '{3, 1, 0, -1, -1, -1, -1, -1};
    f3 = int'(ins[14:12]);
    f7 = ins[31:25];
    ok = 1'b1;
    e = '0;
    case (ins[6:0])
      7'h33: begin
        e.regwrite = 1; e.use1 = 1; e.use2 = 1;
        if (f7 == 7'h00) e.aluop = 5'(r_op[f3]);
        else if (f7 == 7'h20 && f3 == 0) e.aluop = 5'd4;
        else if (f7 == 7'h20 && f3 == 5) e.aluop = 5'd17;
`ifdef DECODE_RV32M_EN
        else if (f7 == 7'h01) e.aluop = 5'(18 + f3);
`endif
        else ok = 0;
      end
      7'h13: begin
        e.regwrite = 1; e.alusrc = 1; e.use1 = 1;
        e.extop = (f3 == 1 || f3 == 5) ? 6'b100000 : 6'b010000;
        e.aluop = (f3 == 5 && f7 == 7'h20) ? 5'd17 : 5'(r_op[f3]);
        if (f3 == 1 && f7 != 7'h00) ok = 0;
        if (f3 == 5 && f7 != 7'h00 && f7 != 7'h20) ok = 0;
      end
      7'h03: begin
        e.regwrite = 1; e.alusrc = 1; e.is_load = 1; e.use1 = 1;
        e.extop = 6'b010000; e.aluop = 5'd3; e.wdsel = 2'b01;
        if (ld_dm[f3] < 0) ok = 0; else e.dmtype = 3'(ld_dm[f3]);
      end
      7'h23: begin
        e.memwrite = 1; e.alusrc = 1; e.use1 = 1; e.use2 = 1;
        e.extop = 6'b001000; e.aluop = 5'd3;
        if (st_dm[f3] < 0) ok = 0; else e.dmtype = 3'(st_dm[f3]);
      end
      7'h63: begin
        e.use1 = 1; e.use2 = 1; e.extop = 6'b000100; e.npcop = 3'b001;
        if (br_op[f3] < 0) ok = 0; else e.aluop = 5'(br_op[f3]);
      end
      7'h6f: begin
        e.regwrite = 1; e.alusrc = 1; e.extop = 6'b000001; e.npcop = 3'b010; e.wdsel = 2'b10;
      end
      7'h67: begin
        e.regwrite = 1; e.alusrc = 1; e.use1 = 1; e.extop = 6'b010000;
        e.aluop = 5'd3; e.npcop = 3'b100; e.wdsel = 2'b10;
        if (f3 != 0) ok = 0;
      end
      7'h37: begin e.regwrite = 1; e.alusrc = 1; e.extop = 6'b000010; e.aluop = 5'd1; end
      7'h17: begin e.regwrite = 1; e.alusrc = 1; e.extop = 6'b000010; e.aluop = 5'd2; end
      default: ok = 0;
    endcase
    if (e.regwrite) e.rd = ins[11:7];
    if (!ok) begin
      e = '0;
      e.illegal = 1;
    end
    e.pc    = pc;
    e.instr = ins;
    return e;
  endfunction

  // Transaction-level pipeline model: one-deep holding slot, trap flag, bubble counter.
  bit       m_held, m_ld, m_trap;
  bit [4:0] m_rd;
  int       m_cnt;
  exp_t     m_d;
  bit       m_free, m_hz, m_rdy;

  always @(negedge clk) begin
    if (rst) begin
      chk("if_ready_in_reset", 32'(bus.if_ready), 32'd0);
      exp_q.delete();
      m_held = 0; m_ld = 0; m_rd = 0; m_trap = 0; m_cnt = 0;
    end else begin
      m_d    = ref_decode(bus.if_instr, bus.if_pc);
      m_free = !m_held || bus.ex_ready;
      m_hz   = bus.if_valid && m_held && m_ld && (m_rd != 0) &&
               ((m_d.use1 && bus.if_instr[19:15] == m_rd) || (m_d.use2 && bus.if_instr[24:20] == m_rd));
      m_rdy  = !m_trap && !bus.flush && !m_hz && m_free;
      chk("if_ready", 32'(bus.if_ready), 32'(m_rdy));
      chk("ex_valid", 32'(bus.ex_valid), 32'(m_held));
      chk("trapped", 32'(bus.trapped), 32'(m_trap));
      chk("stall_cnt", 32'(bus.stall_cnt), 32'(m_cnt));
      if (bus.flush) begin
        m_held = 0;
        m_trap = 0;
      end else begin
        if (m_hz && m_free && m_cnt < (2 ** CNT_W) - 1) m_cnt++;
        if (bus.if_valid && m_rdy) begin
          exp_q.push_back(m_d);
          m_held = 1; m_ld = m_d.is_load; m_rd = m_d.rd;
          if (m_d.illegal) m_trap = 1;
        end else if (m_free) begin
          m_held = 0;
        end
      end
    end
  end

  exp_t mon_e;
  always @(negedge clk) begin
    if (!rst && bus.ex_valid && (bus.ex_ready || bus.flush)) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_bundle", 32'(bus.ex_valid), 32'd0);
      end else begin
        mon_e = exp_q.pop_front();
        if (bus.ex_ready) begin
          chk("ex_pc", bus.ex_pc, mon_e.pc);
          chk("ex_instr", bus.ex_instr, mon_e.instr);
          chk("ex_ctrl",
              32'({bus.ex_rd, bus.ex_regwrite, bus.ex_memwrite, bus.ex_alusrc, bus.ex_is_load,
                   bus.ex_extop, bus.ex_aluop, bus.ex_npcop, bus.ex_dmtype, bus.ex_wdsel, bus.ex_illegal}),
              32'({mon_e.rd, mon_e.regwrite, mon_e.memwrite, mon_e.alusrc, mon_e.is_load,
                   mon_e.extop, mon_e.aluop, mon_e.npcop, mon_e.dmtype, mon_e.wdsel, mon_e.illegal}));
        end
      end
    end
  end

  logic [31:0] pc = 32'h1000;

  task automatic apply(input logic v, input logic [31:0] ins, input logic er, input logic fl);
    bus.if_valid = v;
    bus.if_instr = ins;
    bus.if_pc    = pc;
    bus.ex_ready = er;
    bus.flush    = fl;
    pc = pc + 32'd4;
    #1;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] rand_instr();
    logic [31:0] w;
    logic [6:0]  ops[10];
    ops = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6f, 7'h67, 7'h37, 7'h17, 7'h00};
    w = $urandom;
    w[6:0] = ops[$urandom_range(0, 9)];
    if (w[6:0] == 7'h00) w[6:0] = 7'($urandom);
    w[11:7]  = 5'($urandom_range(0, 3));
    w[19:15] = 5'($urandom_range(0, 3));
    w[24:20] = 5'($urandom_range(0, 3));
    case ($urandom_range(0, 5))
      0, 1, 2: w[31:25] = 7'h00;
      3:       w[31:25] = 7'h20;
      4:       w[31:25] = 7'h01;
      default: ;
    endcase
    return w;
  endfunction

  localparam logic [31:0] ADDI = 32'h00500093;  // addi x1,x0,5
  localparam logic [31:0] LW   = 32'h0000A103;  // lw x2,0(x1)
  localparam logic [31:0] ADD  = 32'h002101B3;  // add x3,x2,x2
  localparam logic [31:0] SUB  = 32'h407302B3;  // sub x5,x6,x7
  localparam logic [31:0] MUL  = 32'h023100B3;  // mul x1,x2,x3

  initial begin
    rst = 1'b1;
    bus.if_valid = 0; bus.if_instr = 0; bus.if_pc = 0; bus.ex_ready = 0; bus.flush = 0;
    repeat (3) @(posedge clk);
    #1;
    apply(1, ADDI, 1, 0);
    chk("reset_if_ready", 32'(bus.if_ready), 32'd0);
    chk("reset_ex_valid", 32'(bus.ex_valid), 32'd0);
    chk("reset_fields", {bus.ex_pc[15:0], 11'(bus.ex_aluop), bus.ex_regwrite, bus.ex_illegal,
                         bus.trapped, bus.ex_rd[1:0]}, 32'd0);
    chk("reset_stall_cnt", 32'(bus.stall_cnt), 32'd0);
    rst = 1'b0;
    step();
    chk("addi_valid", 32'(bus.ex_valid), 32'd1);
    chk("addi_aluop", 32'(bus.ex_aluop), 32'd3);
    chk("addi_alusrc", 32'(bus.ex_alusrc), 32'd1);
    chk("addi_extop", 32'(bus.ex_extop), 32'b010000);
    chk("addi_rd", 32'(bus.ex_rd), 32'd1);

    apply(1, LW, 1, 0);
    step();
    apply(1, ADD, 1, 0);
    chk("hazard_if_ready", 32'(bus.if_ready), 32'd0);
    step();
    chk("bubble_valid", 32'(bus.ex_valid), 32'd0);
    chk("bubble_cnt", 32'(bus.stall_cnt), 32'd1);
    step();
    chk("add_after_bubble", {27'(bus.ex_valid), bus.ex_aluop}, {27'd1, 5'd3});

    apply(1, SUB, 1, 0);
    step();
    for (int i = 0; i < 3; i++) begin
      apply(1, ADDI, 0, 0);
      chk("hold_if_ready", 32'(bus.if_ready), 32'd0);
      step();
      chk("hold_sub", {bus.ex_instr[31:5], bus.ex_aluop}, {SUB[31:5], 5'd4});
    end
    apply(1, ADDI, 1, 0);
    step();
    chk("release_aluop", 32'(bus.ex_aluop), 32'd3);

    apply(1, 32'hFFFFFFFF, 1, 0);
    step();
    chk("illegal_flag", {30'd0, bus.ex_illegal, bus.trapped}, 32'd3);
    for (int i = 0; i < 2; i++) begin
      apply(1, ADDI, 1, 0);
      chk("trap_if_ready", 32'(bus.if_ready), 32'd0);
      step();
    end
    apply(1, ADDI, 1, 1);
    step();
    chk("trap_cleared", 32'(bus.trapped), 32'd0);
    apply(1, ADDI, 1, 0);
    chk("post_trap_ready", 32'(bus.if_ready), 32'd1);
    step();

    apply(1, MUL, 1, 0);
    step();
`ifdef DECODE_RV32M_EN
    chk("mul_decode", {26'd0, bus.ex_aluop, bus.trapped}, {26'd0, 5'd18, 1'b0});
`else
    chk("mul_illegal", {30'd0, bus.ex_illegal, bus.trapped}, 32'd3);
`endif
    apply(1, ADDI, 1, 1);
    step();

    apply(1, LW, 1, 0);
    step();
    apply(1, ADD, 0, 1);
    step();
    chk("flush_hazard_valid", 32'(bus.ex_valid), 32'd0);
    chk("flush_hazard_cnt", 32'(bus.stall_cnt), 32'd1);

    for (int i = 0; i < 3000; i++) begin
      if (i == 1500) begin
        rst = 1'b1;
        apply(1, rand_instr(), 1, 0);
        step();
        step();
        rst = 1'b0;
      end
      apply($urandom_range(0, 9) < 8, rand_instr(), $urandom_range(0, 3) != 0,
            m_trap ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 19) == 0));
      step();
    end

    apply(0, 32'd0, 1, 0);
    repeat (5) step();
    chk("scoreboard_drained", exp_q.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
